snd_mix_n: RTL and testbench

- Parametrised N-channel stereo sample mixer. Successor to the fixed BGM+4 SE mixer.
- Runs entirely in the ACLK domain. Sits between the per-channel sample FIFOs (read side) and the serialiser/CDC buffer.
- On each sample request it walks every channel and applies per-channel volume and master volume. It saturates the sums to the output sample width.
- It reports underrun, overrun and clip through sticky flags.

---
 rtl/snd_pkg.sv | 28 ++
 rtl/snd_mix_sat.sv | 35 +++
 rtl/snd_mix_n.sv | 168 ++++++++++++++++
 tb/tb_snd_mix_n.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snd_pkg.sv
// Shared types and helpers for the N-channel stereo sample mixer.
package snd_pkg;

  typedef enum logic [1:0] {StIdle, StAccum, StScale, StOut} state_e;

  function automatic int unsigned acc_width(input int unsigned sample_w,
                                            input int unsigned vol_w,
                                            input int unsigned num_ch);
    return sample_w + vol_w + $clog2(num_ch) + 1;
  endfunction

  function automatic int unsigned unity_vol(input int unsigned vol_w);
    return 1 << (vol_w - 1);
  endfunction

  // Clamp a wide signed value into a w-bit signed range.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/snd_mix_sat.sv
// Master-volume scaling and saturation for one stereo side.
module snd_mix_sat
  import snd_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned VOL_W    = 8,
  parameter int unsigned ACC_W    = 29
) (
  input  logic signed [ACC_W-1:0]    acc,
  input  logic        [VOL_W-1:0]    master,
  output logic        [SAMPLE_W-1:0] value,
  output logic                       clip
);

  localparam int unsigned ProdW = ACC_W + VOL_W + 1;

  logic signed [ACC_W-1:0] acc_sh;
  logic signed [VOL_W:0]   mvol;
  logic signed [ProdW-1:0] prod;
  logic signed [ProdW-1:0] t;
  logic signed [63:0]      t_ext;
  logic signed [63:0]      s_ext;

  always_comb begin
    acc_sh = acc >>> (VOL_W - 1);
    mvol   = {1'b0, master};
    prod   = ProdW'(acc_sh) * ProdW'(mvol);
    t      = prod >>> (VOL_W - 1);
    t_ext  = 64'(t);
    s_ext  = saturate(t_ext, SAMPLE_W);
    value  = SAMPLE_W'(s_ext);
    clip   = (s_ext != t_ext);
  end

endmodule

// File: rtl/snd_mix_n.sv
// N-channel stereo mixer: walks channels one per cycle, applies per-channel
// and master volume, saturates, and reports sticky underrun/overrun/clip.
module snd_mix_n
  import snd_pkg::*;
#(
  parameter int unsigned NUM_CH   = 5,
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned VOL_W    = 8
) (
  input  logic                         ACLK,
  input  logic                         ARST,
  input  logic [NUM_CH-1:0]            CH_VALID,
  input  logic [NUM_CH*2*SAMPLE_W-1:0] CH_DOUT,
  output logic [NUM_CH-1:0]            CH_RD,
  input  logic [NUM_CH-1:0]            CH_ENABLE,
  input  logic [NUM_CH*VOL_W-1:0]      CH_VOLUME,
  input  logic [VOL_W-1:0]             MASTER_VOLUME,
  input  logic                         MIX_REQ,
  output logic                         MIX_VALID,
  output logic [2*SAMPLE_W-1:0]        MIX_DOUT,
  output logic                         BUSY,
  input  logic                         CLR_FLAGS,
  output logic [NUM_CH-1:0]            UNDERRUN,
  output logic                         OVERRUN,
  output logic                         CLIP
);

  localparam int unsigned AccW  = acc_width(SAMPLE_W, VOL_W, NUM_CH);
  localparam int unsigned IdxW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned TermW = SAMPLE_W + VOL_W + 1;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic signed [AccW-1:0]  acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [2*SAMPLE_W-1:0]   dout_q, dout_d;
  logic [NUM_CH-1:0]       under_q, under_d;
  logic                    over_q, over_d;
  logic                    clip_q, clip_d;

  logic [2*SAMPLE_W-1:0]   cur_word;
  logic [VOL_W-1:0]        cur_vol;
  logic                    cur_en, cur_vld, take;
  logic signed [SAMPLE_W-1:0] smp_l, smp_r;
  logic signed [VOL_W:0]   vol_s;
  logic signed [TermW-1:0] term_l, term_r;
  logic [SAMPLE_W-1:0]     sat_l, sat_r;
  logic                    clip_l, clip_r;

  always_comb begin
    cur_word = CH_DOUT[idx_q*2*SAMPLE_W +: 2*SAMPLE_W];
    cur_vol  = CH_VOLUME[idx_q*VOL_W +: VOL_W];
    cur_en   = CH_ENABLE[idx_q];
    cur_vld  = CH_VALID[idx_q];
    take     = (state_q == StAccum) && cur_en && cur_vld;
    smp_l    = cur_word[2*SAMPLE_W-1:SAMPLE_W];
    smp_r    = cur_word[SAMPLE_W-1:0];
    vol_s    = {1'b0, cur_vol};
    term_l   = TermW'(smp_l) * TermW'(vol_s);
    term_r   = TermW'(smp_r) * TermW'(vol_s);
  end

  snd_mix_sat #(
    .SAMPLE_W (SAMPLE_W),
    .VOL_W    (VOL_W),
    .ACC_W    (AccW)
  ) u_sat_l (
    .acc    (acc_l_q),
    .master (MASTER_VOLUME),
    .value  (sat_l),
    .clip   (clip_l)
  );

  snd_mix_sat #(
    .SAMPLE_W (SAMPLE_W),
    .VOL_W    (VOL_W),
    .ACC_W    (AccW)
  ) u_sat_r (
    .acc    (acc_r_q),
    .master (MASTER_VOLUME),
    .value  (sat_r),
    .clip   (clip_r)
  );

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state_q <= StIdle;
      idx_q   <= '0;
      acc_l_q <= '0;
      acc_r_q <= '0;
      dout_q  <= '0;
      under_q <= '0;
      over_q  <= 1'b0;
      clip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_l_q <= acc_l_d;
      acc_r_q <= acc_r_d;
      dout_q  <= dout_d;
      under_q <= under_d;
      over_q  <= over_d;
      clip_q  <= clip_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (MIX_REQ) state_d = StAccum;
      StAccum: if (idx_q == IdxW'(NUM_CH - 1)) state_d = StScale;
      StScale: state_d = StOut;
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    idx_d   = idx_q;
    acc_l_d = acc_l_q;
    acc_r_d = acc_r_q;
    dout_d  = dout_q;
    under_d = under_q;
    over_d  = over_q;
    clip_d  = clip_q;
    unique case (state_q)
      StIdle: begin
        if (MIX_REQ) begin
          idx_d   = '0;
          acc_l_d = '0;
          acc_r_d = '0;
        end
      end
      StAccum: begin
        idx_d = idx_q + 1'b1;
        if (take) begin
          acc_l_d = acc_l_q + AccW'(term_l);
          acc_r_d = acc_r_q + AccW'(term_r);
        end
        if (cur_en && !cur_vld) under_d[idx_q] = 1'b1;
      end
      StScale: begin
        dout_d = {sat_l, sat_r};
        if (clip_l || clip_r) clip_d = 1'b1;
      end
      default: ;
    endcase
    // A request in any non-idle state, including the output cycle, is dropped.
    if (MIX_REQ && state_q != StIdle) over_d = 1'b1;
    if (CLR_FLAGS) begin
      under_d = '0;
      over_d  = 1'b0;
      clip_d  = 1'b0;
    end
  end

  // Strobes are masked during reset so an aborted mix pops nothing further.
  always_comb begin
    CH_RD = '0;
    if (take && !ARST) CH_RD[idx_q] = 1'b1;
    MIX_VALID = (state_q == StOut) && !ARST;
    BUSY      = (state_q != StIdle);
    MIX_DOUT  = dout_q;
    UNDERRUN  = under_q;
    OVERRUN   = over_q;
    CLIP      = clip_q;
  end

endmodule

// File: tb/tb_snd_mix_n.sv
// Self-checking bench for snd_mix_n: timeline-based reference model plus directed cases.
module tb_snd_mix_n;

  localparam int N = 5;
  localparam int S = 16;
  localparam int V = 8;

  logic              ACLK = 1'b0;
  logic              ARST;
  logic [N-1:0]      CH_VALID;
  logic [N*2*S-1:0]  CH_DOUT;
  logic [N-1:0]      CH_RD;
  logic [N-1:0]      CH_ENABLE;
  logic [N*V-1:0]    CH_VOLUME;
  logic [V-1:0]      MASTER_VOLUME;
  logic              MIX_REQ;
  logic              MIX_VALID;
  logic [2*S-1:0]    MIX_DOUT;
  logic              BUSY;
  logic              CLR_FLAGS;
  logic [N-1:0]      UNDERRUN;
  logic              OVERRUN;
  logic              CLIP;

  snd_mix_n #(
    .NUM_CH   (N),
    .SAMPLE_W (S),
    .VOL_W    (V)
  ) dut (
    .ACLK          (ACLK),
    .ARST          (ARST),
    .CH_VALID      (CH_VALID),
    .CH_DOUT       (CH_DOUT),
    .CH_RD         (CH_RD),
    .CH_ENABLE     (CH_ENABLE),
    .CH_VOLUME     (CH_VOLUME),
    .MASTER_VOLUME (MASTER_VOLUME),
    .MIX_REQ       (MIX_REQ),
    .MIX_VALID     (MIX_VALID),
    .MIX_DOUT      (MIX_DOUT),
    .BUSY          (BUSY),
    .CLR_FLAGS     (CLR_FLAGS),
    .UNDERRUN      (UNDERRUN),
    .OVERRUN       (OVERRUN),
    .CLIP          (CLIP)
  );

  always #5 ACLK = ~ACLK;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a mix is a timeline starting at the accepted request cycle.
  function automatic longint scale(input longint a, input logic [V-1:0] m);
    return ((a >>> (V - 1)) * longint'(m)) >>> (V - 1);
  endfunction

  function automatic longint clamp(input longint t);
    if (t > 32767) return 32767;
    if (t < -32768) return -32768;
    return t;
  endfunction

  bit          synced  = 0;
  longint      cyc     = 0;
  longint      req_cyc = -1;
  longint      acc_l, acc_r;
  logic [31:0] m_dout;
  logic [N-1:0] m_under;
  bit          m_over, m_clip;
  int          valid_cnt;
  int          rd_cnt [N];

  always @(negedge ACLK) begin : model
    logic [N-1:0] e_rd;
    bit           act, e_valid;
    longint       ph, tl, tr, sl, sr;
    int           ch;
    logic signed [S-1:0] lv, rv;
    logic [V-1:0] vol;
    logic [S-1:0] ol, orr;
    act = (req_cyc >= 0);
    ph  = cyc - req_cyc;
    e_rd = '0;
    if (act && ph >= 1 && ph <= N && !ARST) begin
      ch = int'(ph) - 1;
      if (CH_ENABLE[ch] && CH_VALID[ch]) e_rd[ch] = 1'b1;
    end
    e_valid = act && (ph == N + 2) && !ARST;
    if (synced) begin
      check("ch_rd", 64'(CH_RD), 64'(e_rd));
      check("mix_valid", 64'(MIX_VALID), 64'(e_valid));
      check("busy", 64'(BUSY), 64'(act));
      check("mix_dout", 64'(MIX_DOUT), 64'(m_dout));
      check("underrun", 64'(UNDERRUN), 64'(m_under));
      check("overrun", 64'(OVERRUN), 64'(m_over));
      check("clip", 64'(CLIP), 64'(m_clip));
    end
    if (MIX_VALID === 1'b1) valid_cnt++;
    for (int i = 0; i < N; i++) if (CH_RD[i] === 1'b1) rd_cnt[i]++;

    if (ARST) begin
      synced  = 1;
      req_cyc = -1;
      acc_l   = 0;
      acc_r   = 0;
      m_dout  = '0;
      m_under = '0;
      m_over  = 0;
      m_clip  = 0;
    end else begin
      if (act && ph >= 1 && ph <= N) begin
        ch  = int'(ph) - 1;
        lv  = CH_DOUT[ch*2*S+S +: S];
        rv  = CH_DOUT[ch*2*S +: S];
        vol = CH_VOLUME[ch*V +: V];
        if (CH_ENABLE[ch]) begin
          if (CH_VALID[ch]) begin
            acc_l += longint'(lv) * longint'(vol);
            acc_r += longint'(rv) * longint'(vol);
          end else begin
            m_under[ch] = 1'b1;
          end
        end
      end
      if (act && ph == N + 1) begin
        tl = scale(acc_l, MASTER_VOLUME);
        tr = scale(acc_r, MASTER_VOLUME);
        sl = clamp(tl);
        sr = clamp(tr);
        ol = S'(sl);
        orr = S'(sr);
        m_dout = {ol, orr};
        if (sl != tl || sr != tr) m_clip = 1;
      end
      if (act && ph == N + 2) req_cyc = -1;
      if (MIX_REQ) begin
        if (act) m_over = 1;
        else begin
          req_cyc = cyc;
          acc_l   = 0;
          acc_r   = 0;
        end
      end
      if (CLR_FLAGS) begin
        m_under = '0;
        m_over  = 0;
        m_clip  = 0;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_ch(input int i, input bit en, input bit vld, input logic [V-1:0] vol,
                        input logic [31:0] word);
    CH_ENABLE[i]          = en;
    CH_VALID[i]           = vld;
    CH_VOLUME[i*V +: V]   = vol;
    CH_DOUT[i*2*S +: 2*S] = word;
  endtask

  task automatic clear_counts();
    valid_cnt = 0;
    for (int i = 0; i < N; i++) rd_cnt[i] = 0;
  endtask

  task automatic pulse_clr();
    CLR_FLAGS = 1'b1;
    step();
    CLR_FLAGS = 1'b0;
  endtask

  // Issues one request and waits (bounded) for MIX_VALID; lat stays 0 on timeout.
  task automatic run_mix(output int lat, output logic [31:0] d);
    bit seen;
    seen = 0;
    lat  = 0;
    d    = '0;
    MIX_REQ = 1'b1;
    step();
    MIX_REQ = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (!seen) begin
        @(negedge ACLK);
        if (MIX_VALID === 1'b1) begin
          seen = 1;
          lat  = k;
          d    = MIX_DOUT;
        end
        step();
      end
    end
  endtask

  initial begin : stim
    int          lat;
    logic [31:0] d;
    ARST = 1'b1;
    CH_VALID = '0;
    CH_DOUT = '0;
    CH_ENABLE = '0;
    CH_VOLUME = '0;
    MASTER_VOLUME = 8'h80;
    MIX_REQ = 1'b0;
    CLR_FLAGS = 1'b0;
    clear_counts();
    repeat (3) step();
    ARST = 1'b0;
    @(negedge ACLK);
    check("rst_dout", 64'(MIX_DOUT), 64'h0);
    check("rst_valid", 64'(MIX_VALID), 64'h0);
    check("rst_busy", 64'(BUSY), 64'h0);
    check("rst_flags", 64'({UNDERRUN, OVERRUN, CLIP}), 64'h0);
    check("rst_rd", 64'(CH_RD), 64'h0);
    step();

    // Single channel at unity: pass-through, latency NUM_CH+2.
    set_ch(0, 1, 1, 8'h80, 32'h1000_F000);
    clear_counts();
    run_mix(lat, d);
    check("t1_latency", 64'(lat), 64'd7);
    check("t1_dout", 64'(d), 64'h1000_F000);
    check("t1_rd0", 64'(rd_cnt[0]), 64'd1);
    check("t1_clip", 64'(CLIP), 64'h0);

    // Two loud channels saturate both sides.
    set_ch(0, 1, 1, 8'h80, 32'h7000_9000);
    set_ch(1, 1, 1, 8'h80, 32'h7000_9000);
    run_mix(lat, d);
    check("t2_dout", 64'(d), 64'h7FFF_8000);
    check("t2_clip", 64'(CLIP), 64'h1);
    pulse_clr();
    check("t2_clip_clr", 64'(CLIP), 64'h0);

    // Channel and master volume halving.
    set_ch(1, 0, 0, 8'h80, 32'h0);
    set_ch(0, 1, 1, 8'h40, 32'h4000_4000);
    run_mix(lat, d);
    check("t3_dout_ch_vol", 64'(d), 64'h2000_2000);
    MASTER_VOLUME = 8'h40;
    run_mix(lat, d);
    check("t3_dout_master", 64'(d), 64'h1000_1000);
    MASTER_VOLUME = 8'h80;

    // Underrun on enabled-but-empty channel; disabled channel never read.
    pulse_clr();
    set_ch(0, 1, 1, 8'h80, 32'h0100_0200);
    set_ch(2, 1, 0, 8'h80, 32'h7777_7777);
    set_ch(3, 0, 1, 8'h80, 32'h7777_7777);
    clear_counts();
    run_mix(lat, d);
    check("t4_dout", 64'(d), 64'h0100_0200);
    check("t4_underrun", 64'(UNDERRUN), 64'h04);
    check("t4_rd2", 64'(rd_cnt[2]), 64'd0);
    check("t4_rd3", 64'(rd_cnt[3]), 64'd0);

    // Request while busy is dropped and flagged.
    pulse_clr();
    clear_counts();
    MIX_REQ = 1'b1;
    step();
    MIX_REQ = 1'b0;
    step();
    MIX_REQ = 1'b1;
    step();
    MIX_REQ = 1'b0;
    repeat (12) step();
    check("t5_valid_count", 64'(valid_cnt), 64'd1);
    check("t5_overrun", 64'(OVERRUN), 64'h1);

    // Reset in the middle of the channel walk aborts the mix.
    for (int i = 0; i < N; i++)
      set_ch(i, 1, 1, 8'h80, {16'(i * 'h100), 16'(-(i * 'h10))});
    clear_counts();
    MIX_REQ = 1'b1;
    step();
    MIX_REQ = 1'b0;
    step();
    step();
    ARST = 1'b1;
    step();
    ARST = 1'b0;
    @(negedge ACLK);
    check("t6_rd_after_rst", 64'(CH_RD), 64'h0);
    check("t6_dout_after_rst", 64'(MIX_DOUT), 64'h0);
    check("t6_busy_after_rst", 64'(BUSY), 64'h0);
    step();
    repeat (10) step();
    check("t6_no_valid", 64'(valid_cnt), 64'd0);
    run_mix(lat, d);
    check("t6_latency", 64'(lat), 64'd7);
    check("t6_dout", 64'(d), 64'h0A00_FF60);

    // Randomized traffic, checked every cycle by the model.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        CH_DOUT[i*2*S +: 2*S] = $urandom;
        CH_VOLUME[i*V +: V]   = 8'($urandom);
      end
      CH_ENABLE     = N'($urandom);
      CH_VALID      = N'($urandom);
      MASTER_VOLUME = 8'($urandom);
      MIX_REQ       = ($urandom_range(0, 3) == 0);
      CLR_FLAGS     = ($urandom_range(0, 39) == 0);
      ARST          = ($urandom_range(0, 299) == 0);
      step();
    end
    ARST = 1'b0;
    MIX_REQ = 1'b0;
    CLR_FLAGS = 1'b0;
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
